// File: rtl/count_sequencer.sv
// Sequencer for the 3-bit binary/Gray counter: divided tick, step/wrap tracking, mode select.
// Latency: all outputs registered, one clock after the inputs that cause them; pause/clear act on the next edge.
module count_sequencer #(
    parameter int OLD_HZ          = 100000000,
    parameter int NEW_HZ          = 1,
    parameter int CYCLES_PER_MODE = 2
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRUN,
    input  logic       iCLEAR,
    input  logic       iAUTO,
    input  logic       iM,
    output logic       oM,
    output logic       oTICK,
    output logic       oWRAP,
    output logic [2:0] oSTEP,
    output logic [7:0] oCYCLES,
    output logic [1:0] oSTATE
);

    localparam int          DIV        = OLD_HZ / NEW_HZ;
    localparam int          PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam int unsigned CYC_LAST   = CYCLES_PER_MODE - 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RUN_BIN  = 2'b01,
        S_RUN_GRAY = 2'b10,
        S_PAUSE    = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          m_q, m_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic [2:0]    step_q, step_d;
    logic [7:0]    cycles_q, cycles_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cyc_done;

    function automatic state_t run_state(input logic mode);
        return mode ? S_RUN_GRAY : S_RUN_BIN;
    endfunction

    // >= rather than == so counts accumulated in manual mode still trigger a toggle.
    assign cyc_done = ({24'd0, cycles_q} >= CYC_LAST);

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        presc_d  = presc_q;
        step_d   = step_q;
        cycles_d = cycles_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;

        if (iCLEAR) begin
            state_d  = S_IDLE;
            presc_d  = '0;
            step_d   = '0;
            cycles_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d  = '0;
                    step_d   = '0;
                    cycles_d = '0;
                    if (iRUN) begin
                        m_d     = !iAUTO && iM;
                        state_d = run_state(!iAUTO && iM);
                    end
                end
                S_RUN_BIN, S_RUN_GRAY: begin
                    if (!iRUN) begin
                        // Prescaler freezes as-is, so a suppressed tick fires right after resume.
                        state_d = S_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        step_d  = step_q + 3'd1;
                        if (step_q == 3'd7) begin
                            wrap_d = 1'b1;
                            if (iAUTO && cyc_done) begin
                                m_d      = !m_q;
                                cycles_d = '0;
                            end else if (!iAUTO && (iM != m_q)) begin
                                m_d      = iM;
                                cycles_d = '0;
                            end else if (cycles_q != 8'hFF) begin
                                cycles_d = cycles_q + 8'd1;
                            end
                            state_d = run_state(m_d);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (iRUN) begin
                        state_d = run_state(m_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q  <= S_IDLE;
            m_q      <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            step_q   <= '0;
            cycles_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            step_q   <= step_d;
            cycles_q <= cycles_d;
            presc_q  <= presc_d;
        end
    end

    assign oM      = m_q;
    assign oTICK   = tick_q;
    assign oWRAP   = wrap_q;
    assign oSTEP   = step_q;
    assign oCYCLES = cycles_q;
    assign oSTATE  = state_q;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences the 3-bit binary/Gray counter datapath.
- Generates the divided count-enable tick and supplies the mode select to the counter.
- Tracks the step index and full 8-step wraps, and alternates binary/Gray mode after a programmable number of wraps.
- Mode changes apply only at wrap boundaries, so every count sequence restarts cleanly at 000.

Parameters:
- OLD_HZ, 100000000, input clock frequency in Hz.
- NEW_HZ, 1, tick rate in Hz. DIV = OLD_HZ/NEW_HZ; DIV must be an integer ≥ 1.
- CYCLES_PER_MODE, 2, full 8-step wraps per mode in auto mode; must be ≥ 1.

Ports:
- iCLOCK input 1: system clock, rising edge.
- inRESET input 1: asynchronous active-low reset.
- iRUN input 1: level; 1 = run, 0 = pause.
- iCLEAR input 1: synchronous; return to IDLE; priority over iRUN.
- iAUTO input 1: 1 = alternate modes automatically; 0 = manual mode via iM.
- iM input 1: manual mode request; 0 = binary, 1 = Gray.
- oM output 1: mode select to the counter datapath.
- oTICK output 1: one-cycle count-enable pulse.
- oWRAP output 1: one-cycle pulse on the tick that takes step 7 to 0.
- oSTEP output 3: current step index, 0..7.
- oCYCLES output 8: wraps completed in the current mode.
- oSTATE output 2: 00 IDLE, 01 RUN_BIN, 10 RUN_GRAY, 11 PAUSE.

Behaviour:
- All outputs are registered.
- Reset (inRESET=0, asynchronous, takes effect immediately):
  - oM=0, oTICK=0, oWRAP=0, oSTEP=0, oCYCLES=0, oSTATE=IDLE.
  - Prescaler=0, saved mode=0.
  - Reset mid-run aborts with no residual pulse.
- IDLE:
  - Prescaler, step and cycles are held at 0.
  - iRUN=1 → RUN_BIN/RUN_GRAY on the next edge.
  - Starting mode = 0 if iAUTO=1, else iM; oM takes that value on the same edge.
- RUN:
  - Prescaler increments each clock.
  - When prescaler = DIV-1 it clears to 0 and oTICK=1 for one cycle, so tick period = DIV clocks.
  - The first tick occurs DIV clocks after entering RUN.
  - If DIV = 1, oTICK is high every RUN cycle.
- On each tick, oSTEP increments mod 8.
- Wrap (tick with oSTEP=7):
  - oWRAP=1 and oSTEP=0.
  - If iAUTO=1 and oCYCLES = CYCLES_PER_MODE-1: mode toggles, oCYCLES=0.
  - Else if iAUTO=0 and iM ≠ oM: mode := iM, oCYCLES=0.
  - Otherwise oCYCLES increments; saturates at 255.
  - The new oM and oSTATE are visible on the same edge as oWRAP, so the next tick counts in the new mode from 000.
- Manual iM changes between wraps are deferred to the next wrap and never applied mid-sequence.
- iAUTO changes take effect at the next wrap decision.
- Pause:
  - RUN with iRUN=0 → PAUSE. Prescaler, oSTEP, oCYCLES and oM are frozen; oTICK=oWRAP=0.
  - PAUSE with iRUN=1 → the saved RUN state. Prescaler resumes from its frozen value, so tick phase is preserved.
- iCLEAR=1 in any state → IDLE next edge with all counts zeroed, regardless of iRUN. oM retains its value until the next start.
- Simultaneous events:
  - iRUN falling on a tick-cycle edge: that tick is suppressed; the prescaler freezes at DIV-1 and the tick fires on the first RUN cycle after resume.
  - iCLEAR on a wrap edge: iCLEAR wins; no oWRAP.
- oTICK and oWRAP never assert outside RUN states.

Test Plan:
- Reset, then pulse inRESET low for 3 ns mid-run → all outputs 0 and oSTATE=00 immediately, before any clock edge.
- DIV=2, CYCLES_PER_MODE=2, iAUTO=1, iRUN=1 → oTICK every 2nd clock.
  - oWRAP on ticks 8 and 16; oCYCLES=1 after tick 8.
  - At tick 16: oM 0→1, oSTATE 01→10, oCYCLES=0.
  - At tick 32: oM back to 0.
- Run to oSTEP=3, drop iRUN for 7 clocks → oSTATE=11; oSTEP stays 3; no ticks. Raise iRUN → next tick gives oSTEP=4 with prescaler phase preserved.
- iAUTO=0, iM=0, run; set iM=1 at oSTEP=5 → oM stays 0 until the tick 7→0, then oM=1 and oSTATE=10 on the same edge as oWRAP.
- Assert iCLEAR and iRUN together on the wrap edge → next state IDLE; oSTEP=0, oCYCLES=0, no oWRAP. Release iCLEAR → restart per iM.
- DIV=1 (OLD_HZ=NEW_HZ) → oTICK high every RUN clock; oWRAP every 8 clocks.
